// File: rtl/is_uart_rx.sv
// rtl/is_uart_rx.sv - UART receive deserializer: midpoint sampling, LSB-first, parity/frame error strobes
module is_uart_rx #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD_RATE   = 115200,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_EN   = 0,
    parameter int PARITY_ODD  = 0
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 uart_rxd_r_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    output logic                 parity_err_o,
    output logic                 frame_err_o,
    output logic                 busy_o
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int HALF         = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] HALF_M1  = CW'(HALF - 1);
    localparam logic [CW-1:0] BIT_M1   = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    LAST_IDX = 4'(DATA_BITS - 1);
    localparam logic          ODD      = (PARITY_ODD != 0);

    if (CLKS_PER_BIT < 4) begin : g_cpb_chk
        $error("is_uart_rx: CLKS_PER_BIT must be at least 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_db_chk
        $error("is_uart_rx: DATA_BITS must be 5..9");
    end

    typedef enum logic [2:0] {
        S_ARM,
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [3:0]           idx_q, idx_d;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic                 perr_lat_q, perr_lat_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 busy_q, busy_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        sh_d       = sh_q;
        perr_lat_d = perr_lat_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        perr_d     = 1'b0;
        ferr_d     = 1'b0;
        busy_d     = busy_q;

        case (state_q)
            // The synchronizer comes out of reset low; wait for a full bit time of idle-high.
            S_ARM: begin
                busy_d = 1'b0;
                if (!uart_rxd_r_i) begin
                    cnt_d = '0;
                end else if (cnt_q == BIT_M1) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_IDLE: begin
                busy_d = 1'b0;
                cnt_d  = '0;
                if (!uart_rxd_r_i) begin
                    state_d    = S_START;
                    busy_d     = 1'b1;
                    perr_lat_d = 1'b0;
                end
            end
            S_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    if (uart_rxd_r_i) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = S_DATA;
                        idx_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_M1) begin
                    cnt_d = '0;
                    sh_d  = {uart_rxd_r_i, sh_q[DATA_BITS-1:1]};
                    if (idx_q == LAST_IDX) begin
                        state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_PARITY: begin
                if (cnt_q == BIT_M1) begin
                    cnt_d      = '0;
                    perr_lat_d = uart_rxd_r_i ^ (^sh_q) ^ ODD;
                    state_d    = S_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (cnt_q == BIT_M1) begin
                    cnt_d  = '0;
                    busy_d = 1'b0;
                    if (uart_rxd_r_i) begin
                        valid_d = 1'b1;
                        data_d  = sh_q;
                        perr_d  = perr_lat_q;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_ARM;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_ARM;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= S_ARM;
            cnt_q      <= '0;
            idx_q      <= '0;
            sh_q       <= '0;
            perr_lat_q <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            sh_q       <= sh_d;
            perr_lat_q <= perr_lat_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            busy_q     <= busy_d;
        end
    end

    assign data_o       = data_q;
    assign valid_o      = valid_q;
    assign parity_err_o = perr_q;
    assign frame_err_o  = ferr_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_is_uart_rx.sv
// tb/tb_is_uart_rx.sv - bench for is_uart_rx (8N1 and 8E1 instances) against a line-timeline reference model
module tb_is_uart_rx;

    localparam int CPB  = 16;
    localparam int HALF = 8;
    localparam int DB   = 8;
    localparam int MAXN = 4096;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       rxd = 1'b0;
    logic [7:0] d0, d1;
    logic       v0, v1, pe0, pe1, fe0, fe1, b0, b1;

    always #5 clk = ~clk;

    is_uart_rx #(
        .CLK_FREQ_HZ(1_843_200), .BAUD_RATE(115200), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)
    ) u_dut_n (
        .clk_i(clk), .rstn_i(rstn), .uart_rxd_r_i(rxd), .data_o(d0), .valid_o(v0),
        .parity_err_o(pe0), .frame_err_o(fe0), .busy_o(b0)
    );

    is_uart_rx #(
        .CLK_FREQ_HZ(1_843_200), .BAUD_RATE(115200), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)
    ) u_dut_e (
        .clk_i(clk), .rstn_i(rstn), .uart_rxd_r_i(rxd), .data_o(d1), .valid_o(v1),
        .parity_err_o(pe1), .frame_err_o(fe1), .busy_o(b1)
    );

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   line_q[$];
    logic e_v  [0:1][0:MAXN-1];
    logic e_pe [0:1][0:MAXN-1];
    logic e_fe [0:1][0:MAXN-1];
    logic e_b  [0:1][0:MAXN-1];
    logic [7:0] e_d [0:1][0:MAXN-1];
    int   first_v [0:1];
    int   first_fe [0:1];
    int   first_pe [0:1];
    int   nval [0:1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic add(input bit v, input int n);
        for (int i = 0; i < n; i++) line_q.push_back(v);
    endtask

    // pbit < 0 means no parity bit on the wire
    task automatic add_frame(input logic [7:0] b, input int pbit, input bit stop);
        add(1'b0, CPB);
        for (int i = 0; i < DB; i++) add(b[i], CPB);
        if (pbit >= 0) add(pbit[0], CPB);
        add(stop, CPB);
    endtask

    function automatic void mark_busy(input int d, input int a, input int b, input int n);
        for (int c = a; c <= b && c < n; c++) e_b[d][c] = 1'b1;
    endfunction

    // Walks the line timeline: arming run, start edge, midpoint samples by index arithmetic.
    function automatic void model(input int d, input int pen);
        int n = line_q.size();
        int t = 0;
        int run;
        int s;
        int ts;
        bit arm = 1'b1;
        logic [7:0] sh;
        logic pl;
        logic [7:0] hold = 8'h00;
        for (int c = 0; c < n; c++) begin
            e_v[d][c] = 1'b0; e_pe[d][c] = 1'b0; e_fe[d][c] = 1'b0;
            e_b[d][c] = 1'b0; e_d[d][c] = 8'h00;
        end
        while (t < n) begin
            if (arm) begin
                run = 0;
                while (t < n && run < CPB) begin
                    run = line_q[t] ? run + 1 : 0;
                    t++;
                end
                arm = 1'b0;
            end else begin
                while (t < n && line_q[t]) t++;
                if (t >= n) break;
                s = t;
                if (s + HALF >= n) begin
                    mark_busy(d, s + 1, n - 1, n);
                    break;
                end
                if (line_q[s + HALF]) begin
                    mark_busy(d, s + 1, s + HALF, n);
                    t = s + HALF + 1;
                end else begin
                    ts = s + HALF + CPB * (DB + 1 + pen);
                    if (ts >= n) begin
                        mark_busy(d, s + 1, n - 1, n);
                        break;
                    end
                    for (int k = 0; k < DB; k++) sh[k] = line_q[s + HALF + CPB * (k + 1)];
                    pl = (pen != 0) ? (line_q[s + HALF + CPB * (DB + 1)] != (^sh)) : 1'b0;
                    mark_busy(d, s + 1, ts, n);
                    if (ts + 1 < n) begin
                        if (line_q[ts]) begin
                            e_v[d][ts + 1]  = 1'b1;
                            e_pe[d][ts + 1] = pl;
                            e_d[d][ts + 1]  = sh;
                        end else begin
                            e_fe[d][ts + 1] = 1'b1;
                        end
                    end
                    arm = !line_q[ts];
                    t = ts + 1;
                end
            end
        end
        for (int c = 0; c < n; c++) begin
            if (e_v[d][c]) hold = e_d[d][c];
            e_d[d][c] = hold;
        end
    endfunction

    task automatic play();
        while (line_q.size() > MAXN) void'(line_q.pop_back());
        model(0, 0);
        model(1, 1);
        for (int d = 0; d < 2; d++) begin
            first_v[d] = -1; first_fe[d] = -1; first_pe[d] = -1; nval[d] = 0;
        end
        rstn = 1'b0;
        rxd  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cyc = -1;
        check("rst_strobes", {v0, v1, pe0, pe1, fe0, fe1, b0, b1}, 32'h0);
        check("rst_data", {d0, d1}, 32'h0);
        rstn = 1'b1;
        for (int t = 0; t < line_q.size(); t++) begin
            cyc = t;
            rxd = line_q[t];
            check("n_valid", v0, e_v[0][t]);
            check("n_perr", pe0, e_pe[0][t]);
            check("n_ferr", fe0, e_fe[0][t]);
            check("n_busy", b0, e_b[0][t]);
            check("n_data", d0, e_d[0][t]);
            check("e_valid", v1, e_v[1][t]);
            check("e_perr", pe1, e_pe[1][t]);
            check("e_ferr", fe1, e_fe[1][t]);
            check("e_busy", b1, e_b[1][t]);
            check("e_data", d1, e_d[1][t]);
            if (v0) begin nval[0]++; if (first_v[0] < 0) first_v[0] = t; end
            if (v1) begin nval[1]++; if (first_v[1] < 0) first_v[1] = t; end
            if (fe0 && first_fe[0] < 0) first_fe[0] = t;
            if (fe1 && first_fe[1] < 0) first_fe[1] = t;
            if (pe0 && first_pe[0] < 0) first_pe[0] = t;
            if (pe1 && first_pe[1] < 0) first_pe[1] = t;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [7:0] rb;
        // 1: synchronizer low after reset, short idle, then a properly armed frame
        line_q.delete();
        add(1'b0, 40); add(1'b1, 10); add_frame(8'h55, -1, 1'b1); add(1'b1, 40);
        play();
        line_q.delete();
        add(1'b0, 40); add(1'b1, 20); add_frame(8'h55, -1, 1'b1); add(1'b1, 40);
        play();
        check("arm_ok_count", nval[0], 1);

        // 2: 0xA3 8N1 latency
        line_q.delete();
        add(1'b1, 30); add_frame(8'hA3, -1, 1'b1); add(1'b1, 30);
        play();
        check("a3_latency", first_v[0], 30 + 153);
        check("a3_count", nval[0], 1);

        // 3: short low glitch rejected, following frame received
        line_q.delete();
        add(1'b1, 30); add(1'b0, 4); add(1'b1, 30); add_frame(8'h3C, -1, 1'b1); add(1'b1, 30);
        play();
        check("glitch_latency", first_v[0], 64 + 153);
        check("glitch_count", nval[0], 1);

        // 4: frame error, re-arm needed before the next frame
        line_q.delete();
        add(1'b1, 30); add_frame(8'h81, -1, 1'b0);
        add(1'b1, 8); add_frame(8'h00, -1, 1'b1);
        add(1'b1, 16); add_frame(8'h81, -1, 1'b1); add(1'b1, 30);
        play();
        check("ferr_latency", first_fe[0], 30 + 153);
        check("ferr_rearm_count", nval[0], 1);

        // 5: even parity, wrong then right parity bit
        line_q.delete();
        add(1'b1, 30); add_frame(8'h07, 0, 1'b1); add(1'b1, 30); add_frame(8'h07, 1, 1'b1); add(1'b1, 30);
        play();
        check("par_latency", first_v[1], 30 + 169);
        check("par_err_at", first_pe[1], 30 + 169);
        check("par_count", nval[1], 2);

        // 6: back-to-back frames, then reset during bit 4 of a third
        line_q.delete();
        add(1'b1, 30); add_frame(8'h12, -1, 1'b1); add_frame(8'h34, -1, 1'b1);
        rb = 8'h56;
        add(1'b0, CPB);
        for (int i = 0; i < 4; i++) add(rb[i], CPB);
        add(rb[4], 8);
        play();
        check("b2b_count", nval[0], 2);
        #3;
        rstn = 1'b0;
        #1;
        cyc = -2;
        check("midrst_strobes", {v0, v1, pe0, pe1, fe0, fe1, b0, b1}, 32'h0);
        check("midrst_data", {d0, d1}, 32'h0);
        line_q.delete();
        add(rb[4], 8);
        for (int i = 5; i < DB; i++) add(rb[i], CPB);
        add(1'b1, CPB); add(1'b1, 40);
        play();
        check("midrst_tail_count", nval[0], 0);

        // random frames, formats, gaps, glitches and broken stop bits
        for (int seg = 0; seg < 8; seg++) begin
            line_q.delete();
            add(1'b1, $urandom_range(16, 40));
            repeat ($urandom_range(3, 6)) begin
                rb = 8'($urandom);
                if ($urandom_range(0, 5) == 0) begin
                    add(1'b0, $urandom_range(1, 7));
                    add(1'b1, $urandom_range(9, 20));
                end
                add_frame(rb, ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 1)),
                          $urandom_range(0, 7) != 0);
                add(1'b1, $urandom_range(0, 24));
            end
            add(1'b1, 40);
            play();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
